// File: rtl/if_prefetch_stage.sv
// if_prefetch_stage
// Prefetching instruction-fetch stage. It keeps up to MAX_OUTST line requests
// in flight on an SRAM-like bus (addr_ok/data_ok), buffers returned 64-bit
// lines in a FIFO_DEPTH-entry line FIFO and hands one 32-bit instruction per
// cycle to ID. A redirect flushes the FIFO and drops responses that are still
// in flight for the old stream.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   redirect_valid/pc    flush and restart fetch at redirect_pc
//   id_ready             ID accepts inst this cycle
//   if_req_valid/op      fetch request (op is always read)
//   inst_addr            line-aligned fetch address
//   inst_addr_ok         request accepted this cycle
//   inst_data_ok/data    line returned this cycle, in request order
//   inst/inst_pc/valid   instruction presented to ID
//   stall_req            no instruction available while running
//
// Optional build macro
//   IF_BYPASS_EN  a kept response arriving at an empty FIFO drives inst in
//                 the same cycle; a line fully consumed that cycle is not
//                 written to the FIFO.
module if_prefetch_stage #(
  parameter int unsigned       ADDR_W     = 64,
  parameter int unsigned       LINE_W     = 64,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter int unsigned       MAX_OUTST  = 2,
  parameter logic [ADDR_W-1:0] PC_START   = ADDR_W'(64'h8000_0000)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              id_ready,
  output logic              if_req_valid,
  output logic              if_req_op,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [LINE_W-1:0] inst_data,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  output logic              stall_req
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OUT_W = $clog2(MAX_OUTST + 1);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned TAG_W = ADDR_W - 3;

  typedef enum logic [1:0] {
    RESET_WAIT = 2'd0,
    RUN        = 2'd1,
    DRAIN      = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  fpc_q, fpc_d;
  logic [TAG_W-1:0]   ret_q, ret_d;
  logic               rd_slot_q, rd_slot_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [OUT_W-1:0]   outst_q, outst_d;
  logic [OUT_W-1:0]   drop_q, drop_d;

  logic [LINE_W-1:0]  fifo_line [FIFO_DEPTH];
  logic [TAG_W-1:0]   fifo_tag  [FIFO_DEPTH];

  logic               run;
  logic               redir;
  logic               empty;
  logic               keep;
  logic               byp;
  logic               have;
  logic               fire;
  logic               push;
  logic               pop;
  logic               addr_hs;
  logic [SUM_W-1:0]   inflight;
  logic [LINE_W-1:0]  cur_line;
  logic [TAG_W-1:0]   cur_tag;

  // Address bits [1:0] of a redirect target are zero by contract.
  logic               unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign if_req_op = 1'b0;
  assign inst_addr = fpc_q;

  // Next-state, datapath control and presented outputs.
  always_comb begin
    state_d      = state_q;
    fpc_d        = fpc_q;
    ret_d        = ret_q;
    rd_slot_d    = rd_slot_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    outst_d      = outst_q;
    drop_d       = drop_q;
    push         = 1'b0;
    pop          = 1'b0;
    fire         = 1'b0;
    inst         = 32'd0;
    inst_pc      = '0;

    run          = (state_q != RESET_WAIT);
    redir        = redirect_valid & run;
    empty        = (count_q == '0);
    keep         = inst_data_ok & ~redir & (drop_q == '0);

    // Lines already buffered plus kept responses still in flight must fit,
    // so inst_data_ok never needs back-pressure.
    inflight     = SUM_W'(count_q) + SUM_W'(outst_q) - SUM_W'(drop_q);
    if_req_valid = run & ~redirect_valid
                 & (outst_q < OUT_W'(MAX_OUTST))
                 & (inflight < SUM_W'(FIFO_DEPTH));
    addr_hs      = if_req_valid & inst_addr_ok;

`ifdef IF_BYPASS_EN
    byp          = empty & keep;
`else
    byp          = 1'b0;
`endif

    have         = ~empty | byp;
    cur_line     = byp ? inst_data : fifo_line[rd_ptr_q];
    cur_tag      = byp ? ret_q     : fifo_tag[rd_ptr_q];
    inst_valid   = have & ~redirect_valid;
    if (have) begin
      inst    = rd_slot_q ? cur_line[32 +: 32] : cur_line[0 +: 32];
      inst_pc = {cur_tag, rd_slot_q, 2'b00};
    end
    stall_req    = run & ~inst_valid;

    // Slot 0 -> slot 1 stays on the same line; slot 1 retires the line.
    fire         = inst_valid & id_ready;
    if (fire) begin
      rd_slot_d = ~rd_slot_q;
    end
    pop          = fire & rd_slot_q & ~byp;
    push         = keep & ~(byp & fire & rd_slot_q);

    if (keep) begin
      ret_d = ret_q + TAG_W'(1);
    end
    if (addr_hs) begin
      fpc_d = fpc_q + ADDR_W'(8);
    end
    outst_d = outst_q + OUT_W'(addr_hs) - OUT_W'(inst_data_ok);
    if (inst_data_ok && (drop_q != '0)) begin
      drop_d = drop_q - OUT_W'(1);
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    // Redirect wins over everything: every response still owed by the bus
    // after this cycle belongs to the old stream.
    if (redir) begin
      fpc_d     = {redirect_pc[ADDR_W-1:3], 3'b000};
      ret_d     = redirect_pc[ADDR_W-1:3];
      rd_slot_d = redirect_pc[2];
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      drop_d    = outst_q + OUT_W'(addr_hs) - OUT_W'(inst_data_ok);
    end

    unique case (state_q)
      RESET_WAIT: state_d = RUN;
      RUN, DRAIN: state_d = (drop_d != '0) ? DRAIN : RUN;
      default:    state_d = RESET_WAIT;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Fetch pointers, counters and FIFO bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc_q     <= {PC_START[ADDR_W-1:3], 3'b000};
      ret_q     <= PC_START[ADDR_W-1:3];
      rd_slot_q <= PC_START[2];
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      outst_q   <= '0;
      drop_q    <= '0;
    end else begin
      fpc_q     <= fpc_d;
      ret_q     <= ret_d;
      rd_slot_q <= rd_slot_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      outst_q   <= outst_d;
      drop_q    <= drop_d;
    end
  end

  // Line storage: returned line plus the line address it was fetched from.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_line[i] <= '0;
        fifo_tag[i]  <= '0;
      end
    end else if (push) begin
      fifo_line[wr_ptr_q] <= inst_data;
      fifo_tag[wr_ptr_q]  <= ret_q;
    end
  end

  // A response with nothing outstanding is a bus protocol error.
  bus_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst_n)
    !(inst_data_ok && (outst_q == '0)));

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Testbench for if_prefetch_stage: a bus/memory model answers fetches in
// order with programmable delays, the stimulus pushes expected instruction
// PCs into a queue, and a monitor pops and compares on every ID handshake.
module tb_if_prefetch_stage;

  localparam int unsigned ADDR_W     = 64;
  localparam int unsigned LINE_W     = 64;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned MAX_OUTST  = 2;
  localparam logic [63:0] PC_START   = 64'h8000_0000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              id_ready;
  logic              if_req_valid;
  logic              if_req_op;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [LINE_W-1:0] inst_data;
  logic [31:0]       inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_valid;
  logic              stall_req;

  if_prefetch_stage #(
    .ADDR_W(ADDR_W), .LINE_W(LINE_W), .FIFO_DEPTH(FIFO_DEPTH),
    .MAX_OUTST(MAX_OUTST), .PC_START(PC_START)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_ready(id_ready),
    .if_req_valid(if_req_valid), .if_req_op(if_req_op), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_data(inst_data),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] exp_q [$];
  logic [63:0] pend  [$];
  logic [63:0] exp_addr = PC_START;
  int          dwait = 0;
  int          dly_min = 0, dly_max = 0;
  int          aok_pct = 100, rdy_pct = 100;
  bit          ready_en = 1'b1;
  int          acc_cnt = 0, cons_cnt = 0;

  function automatic logic [31:0] word_of(input logic [63:0] pc);
    return pc[31:0] ^ {pc[15:0], 16'hC3A5};
  endfunction

  function automatic logic [63:0] line_of(input logic [63:0] a);
    return {word_of(a + 64'd4), word_of(a)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_stream(input logic [63:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 64'(4 * i));
  endtask

  // Bus memory model, ID-side driver and scoreboard monitor.
  initial begin : bus
    logic [63:0] e;
    logic [63:0] tmp;
    bit          ok;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_data    = '0;
    id_ready     = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend.delete();
      end else begin
        if (inst_data_ok) begin
          tmp   = pend.pop_front();
          dwait = int'($urandom_range(dly_max, dly_min));
        end
        if (if_req_valid && inst_addr_ok) begin
          check("fetch_addr", inst_addr, exp_addr);
          exp_addr = exp_addr + 64'd8;
          acc_cnt++;
          if (pend.size() == 0) dwait = int'($urandom_range(dly_max, dly_min));
          pend.push_back(inst_addr);
          ok = (pend.size() <= int'(MAX_OUTST));
          check("outst_bound", 64'(ok), 64'd1);
        end
        if (inst_valid && id_ready) begin
          cons_cnt++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_inst: got pc %h, want none", inst_pc);
          end else begin
            e = exp_q.pop_front();
            check("inst_pc", inst_pc, e);
            check("inst", 64'(inst), 64'(word_of(e)));
          end
        end
      end
      @(posedge clk);
      #1;
      inst_data_ok = 1'b0;
      inst_data    = 64'hDEAD_BEEF_0BAD_F00D;
      if (!rst_n) begin
        inst_addr_ok = 1'b0;
        id_ready     = 1'b0;
      end else begin
        inst_addr_ok = ($urandom_range(99) < 32'(aok_pct));
        id_ready     = ready_en && (exp_q.size() != 0) && ($urandom_range(99) < 32'(rdy_pct));
        if (pend.size() != 0) begin
          if (dwait <= 0) begin
            inst_data_ok = 1'b1;
            inst_data    = line_of(pend[0]);
          end else begin
            dwait--;
          end
        end
      end
    end
  end

  task automatic wait_drain(input string name, input int max_cyc);
    int i = 0;
    while (exp_q.size() != 0 && i < max_cyc) begin
      @(posedge clk);
      i++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_timeout: %0d instructions left, want 0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #2;
  endtask

  // Cycle distance between the first data_ok and the first inst_valid.
  task automatic check_first_latency();
    int fd = -1;
    int fv = -1;
    for (int i = 0; i < 40 && (fd < 0 || fv < 0); i++) begin
      @(negedge clk);
      if (fd < 0 && inst_data_ok) fd = i;
      if (fv < 0 && inst_valid)   fv = i;
    end
    if (fd < 0 || fv < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL first_latency_timeout: data_ok at %0d, valid at %0d", fd, fv);
    end else begin
`ifdef IF_BYPASS_EN
      check("first_valid_cycle", 64'(fv), 64'(fd));
`else
      check("first_valid_cycle", 64'(fv), 64'(fd + 1));
`endif
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_if_req_valid"}, 64'(if_req_valid), 64'd0);
    check({tag, "_inst_valid"},   64'(inst_valid),   64'd0);
    check({tag, "_inst"},         64'(inst),         64'd0);
    check({tag, "_inst_pc"},      inst_pc,           64'd0);
    check({tag, "_stall_req"},    64'(stall_req),    64'd0);
  endtask

  initial begin : stim
    bit found;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // Reset values, then stream from PC_START.
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("rst");
    push_stream(PC_START, 12);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    check_first_latency();
    wait_drain("stream", 200);

    // ID stalls: FIFO fills to FIFO_DEPTH lines and fetch stops.
    ready_en = 1'b0;
    push_stream(64'h8000_0030, 8);
    repeat (20) @(posedge clk);
    #2;
    check("stall_if_req_valid", 64'(if_req_valid), 64'd0);
    check("stall_inst_valid",   64'(inst_valid),   64'd1);
    check("stall_stall_req",    64'(stall_req),    64'd0);
    check("stall_head_pc",      inst_pc,           64'h8000_0030);
    check("stall_lines_held",   64'(acc_cnt - cons_cnt / 2), 64'(FIFO_DEPTH));
    ready_en = 1'b1;
    wait_drain("stall_release", 200);

    // Redirect while two requests are outstanding.
    dly_min = 4;
    dly_max = 4;
    push_stream(64'h8000_0050, 40);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk);
      #2;
      if (i >= 10 && pend.size() == 2) found = 1'b1;
    end
    check("redir_outst2_reached", 64'(found), 64'd1);
    exp_q.delete();
    push_stream(64'h8000_1004, 9);
    exp_addr       = 64'h8000_1000;
    redirect_pc    = 64'h8000_1004;
    redirect_valid = 1'b1;
    #1;
    check("redir_inst_valid",   64'(inst_valid),   64'd0);
    check("redir_if_req_valid", 64'(if_req_valid), 64'd0);
    @(posedge clk);
    #2;
    redirect_valid = 1'b0;
    wait_drain("redir_outst", 300);

    // Redirect in the same cycle as a returning line and an ID handshake.
    dly_min = 1;
    dly_max = 1;
    push_stream(64'h8000_1028, 40);
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      @(posedge clk);
      #2;
      if (i >= 4 && inst_data_ok && id_ready && inst_valid) found = 1'b1;
    end
    check("redir_data_hs_found", 64'(found), 64'd1);
    exp_q.delete();
    push_stream(64'h8000_2000, 10);
    exp_addr       = 64'h8000_2000;
    redirect_pc    = 64'h8000_2000;
    redirect_valid = 1'b1;
    #1;
    check("redir2_inst_valid", 64'(inst_valid), 64'd0);
    @(posedge clk);
    #2;
    redirect_valid = 1'b0;
    wait_drain("redir_data_hs", 300);

    // Random bus delays and ID back-pressure, with one redirect mid-stream.
    dly_min = 0;
    dly_max = 5;
    aok_pct = 60;
    rdy_pct = 70;
    push_stream(64'h8000_2028, 50);
    wait_drain("random", 1500);
    push_stream(64'h8000_20F0, 40);
    repeat (12) @(posedge clk);
    #2;
    exp_q.delete();
    push_stream(64'h8000_3004, 30);
    exp_addr       = 64'h8000_3000;
    redirect_pc    = 64'h8000_3004;
    redirect_valid = 1'b1;
    @(posedge clk);
    #2;
    redirect_valid = 1'b0;
    wait_drain("random_redir", 1500);

    // Asynchronous reset in the middle of a burst.
    push_stream(64'h8000_307C, 40);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    exp_q.delete();
    dly_min  = 0;
    dly_max  = 0;
    aok_pct  = 100;
    rdy_pct  = 100;
    repeat (2) @(posedge clk);
    exp_addr = PC_START;
    acc_cnt  = 0;
    cons_cnt = 0;
    push_stream(PC_START, 10);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    check_first_latency();
    wait_drain("after_rst", 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
